// File: rtl/vga_pkg.sv
// Default 640x480 timing constants and frame-size helpers shared by the VGA timing blocks.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CW       = 10;

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate strobe: one clk-wide tick every CLK_DIV enabled clk cycles.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  generate
    if (CLK_DIV <= 1) begin : g_passthru
      // Every enabled cycle is a pixel, so no divider state is needed.
      logic unused_clk;
      assign unused_clk = clk;
      assign tick = en && !reset;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

      logic [DW-1:0] div_q;
      logic [DW-1:0] div_d;

      always_comb begin
        div_d = div_q;
        if (en) begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          div_q <= '0;
        end else begin
          div_q <= div_d;
        end
      end

      assign tick = en && !reset && (div_q == DIV_LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync and blanking decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_field
      $error("vga_timing_gen: every timing field must be non-zero");
    end
    if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic          tick;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_q, video_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  // Decode is taken from the next counter values so the registered syncs line up with the counters.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    hsync_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vsync_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    video_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      video_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
    end
  end

  assign p_tick      = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign line_start  = tick && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance, a CLK_DIV=3 full-height instance
// for frame-level checks, and a tiny CLK_DIV=1 inverted-hsync instance.
module tb_vga_timing_gen;

  logic clk;
  int   testsRun;
  int   testsFailed;

  logic       resetD, enD;
  logic       pTickD, hsyncD, vsyncD, videoOnD, lineStartD, frameStartD;
  logic [9:0] pixelXD, pixelYD;

  logic       resetM, enM;
  logic       pTickM, hsyncM, vsyncM, videoOnM, lineStartM, frameStartM;
  logic [9:0] pixelXM, pixelYM;

  logic       resetS, enS;
  logic       pTickS, hsyncS, vsyncS, videoOnS, lineStartS, frameStartS;
  logic [9:0] pixelXS, pixelYS;

  vga_timing_gen dutD (
    .clk(clk), .reset(resetD), .en(enD), .p_tick(pTickD), .hsync(hsyncD), .vsync(vsyncD),
    .video_on(videoOnD), .pixel_x(pixelXD), .pixel_y(pixelYD),
    .line_start(lineStartD), .frame_start(frameStartD)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)
  ) dutM (
    .clk(clk), .reset(resetM), .en(enM), .p_tick(pTickM), .hsync(hsyncM), .vsync(vsyncM),
    .video_on(videoOnM), .pixel_x(pixelXM), .pixel_y(pixelYM),
    .line_start(lineStartM), .frame_start(frameStartM)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .HS_POL(1'b1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dutS (
    .clk(clk), .reset(resetS), .en(enS), .p_tick(pTickS), .hsync(hsyncS), .vsync(vsyncS),
    .video_on(videoOnS), .pixel_x(pixelXS), .pixel_y(pixelYS),
    .line_start(lineStartS), .frame_start(frameStartS)
  );

  // Free-running 10 ns clock shared by all three instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 ns past the last one, where outputs are stable.
  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    resetD = 1'b1;
    enD    = 1'b1;
    stepClk(2);
    testsRun++; if (pixelXD !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_pixel_x: got %0d expected 0", pixelXD); end
    testsRun++; if (pixelYD !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_pixel_y: got %0d expected 0", pixelYD); end
    testsRun++; if (hsyncD !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_hsync: got %b expected 1", hsyncD); end
    testsRun++; if (vsyncD !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_vsync: got %b expected 1", vsyncD); end
    testsRun++; if (videoOnD !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_video_on: got %b expected 1", videoOnD); end
    testsRun++; if (pTickD !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_p_tick: got %b expected 0", pTickD); end
    testsRun++; if (lineStartD !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_line_start: got %b expected 0", lineStartD); end
    testsRun++; if (frameStartD !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frameStartD); end
  endtask

  // Cycle 1 is the one that begins at the last reset edge; ticks fall in cycles 4, 8, 12.
  task automatic test_tick();
    logic       expTick;
    logic [9:0] expX;
    resetD = 1'b0;
    #1;
    for (int n = 1; n <= 12; n++) begin
      expTick = (n % 4 == 0);
      expX    = 10'((n - 1) / 4);
      testsRun++; if (pTickD !== expTick) begin testsFailed++; $display("[TB] FAIL tick_cycle%0d: got %b expected %b", n, pTickD, expTick); end
      testsRun++; if (pixelXD !== expX) begin testsFailed++; $display("[TB] FAIL tick_pixel_x_cycle%0d: got %0d expected %0d", n, pixelXD, expX); end
      testsRun++; if (lineStartD !== (n == 4)) begin testsFailed++; $display("[TB] FAIL tick_line_start_cycle%0d: got %b expected %b", n, lineStartD, (n == 4)); end
      testsRun++; if (frameStartD !== (n == 4)) begin testsFailed++; $display("[TB] FAIL tick_frame_start_cycle%0d: got %b expected %b", n, frameStartD, (n == 4)); end
      stepClk(1);
    end
  endtask

  task automatic test_line();
    int ticks = 0, cyc = 0, hsLow = 0, vid = 0, yErr = 0;
    int firstHs = -1, lastHs = -1, lastX = -1;
    resetD = 1'b1;
    stepClk(1);
    resetD = 1'b0;
    #1;
    while (ticks < 800 && cyc < 4000) begin
      if (pTickD === 1'b1) begin
        if (hsyncD === 1'b0) begin
          if (firstHs < 0) firstHs = int'(pixelXD);
          lastHs = int'(pixelXD);
          hsLow++;
        end
        if (videoOnD === 1'b1) vid++;
        if (pixelYD !== 10'd0) yErr++;
        lastX = int'(pixelXD);
        ticks++;
      end
      stepClk(1);
      cyc++;
    end
    testsRun++; if (cyc != 3200) begin testsFailed++; $display("[TB] FAIL line_clk_count: got %0d expected 3200", cyc); end
    testsRun++; if (lastX != 799) begin testsFailed++; $display("[TB] FAIL line_last_x: got %0d expected 799", lastX); end
    testsRun++; if (hsLow != 96) begin testsFailed++; $display("[TB] FAIL line_hsync_width: got %0d expected 96", hsLow); end
    testsRun++; if (firstHs != 656) begin testsFailed++; $display("[TB] FAIL line_hsync_first: got %0d expected 656", firstHs); end
    testsRun++; if (lastHs != 751) begin testsFailed++; $display("[TB] FAIL line_hsync_last: got %0d expected 751", lastHs); end
    testsRun++; if (vid != 640) begin testsFailed++; $display("[TB] FAIL line_video_pixels: got %0d expected 640", vid); end
    testsRun++; if (yErr != 0) begin testsFailed++; $display("[TB] FAIL line_y_stable: got %0d bad samples expected 0", yErr); end
    testsRun++; if (pixelXD !== 10'd0) begin testsFailed++; $display("[TB] FAIL line_wrap_x: got %0d expected 0", pixelXD); end
    testsRun++; if (pixelYD !== 10'd1) begin testsFailed++; $display("[TB] FAIL line_wrap_y: got %0d expected 1", pixelYD); end
    testsRun++; if (hsyncD !== 1'b1 || videoOnD !== 1'b1) begin testsFailed++; $display("[TB] FAIL line_wrap_decode: got hsync=%b video_on=%b expected 1/1", hsyncD, videoOnD); end
  endtask

  // Freeze with the divider on its last count, so a lost or doubled tick shows up on resume.
  task automatic test_en_hold();
    int cyc = 0, holdErr = 0;
    while (pixelXD !== 10'd100 && cyc < 1000) begin
      stepClk(1);
      cyc++;
    end
    testsRun++; if (pixelXD !== 10'd100) begin testsFailed++; $display("[TB] FAIL hold_reach_x100: got %0d expected 100", pixelXD); end
    stepClk(3);
    testsRun++; if (pTickD !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_pre_tick: got %b expected 1", pTickD); end
    enD = 1'b0;
    #1;
    testsRun++; if (pTickD !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_tick_masked: got %b expected 0", pTickD); end
    for (int i = 0; i < 37; i++) begin
      stepClk(1);
      if (pixelXD !== 10'd100 || pixelYD !== 10'd1 || pTickD !== 1'b0 ||
          lineStartD !== 1'b0 || frameStartD !== 1'b0) holdErr++;
    end
    testsRun++; if (holdErr != 0) begin testsFailed++; $display("[TB] FAIL hold_frozen: got %0d bad cycles expected 0", holdErr); end
    enD = 1'b1;
    #1;
    testsRun++; if (pTickD !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_resume_tick: got %b expected 1", pTickD); end
    stepClk(1);
    testsRun++; if (pixelXD !== 10'd101) begin testsFailed++; $display("[TB] FAIL hold_resume_x: got %0d expected 101", pixelXD); end
    testsRun++; if (pTickD !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_no_double_tick: got %b expected 0", pTickD); end
    stepClk(3);
    testsRun++; if (pTickD !== 1'b1 || pixelXD !== 10'd101) begin testsFailed++; $display("[TB] FAIL hold_next_period: got tick=%b x=%0d expected 1/101", pTickD, pixelXD); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    while (!(pixelXD === 10'd700 && pixelYD === 10'd1) && cyc < 4000) begin
      stepClk(1);
      cyc++;
    end
    testsRun++; if (pixelXD !== 10'd700 || pixelYD !== 10'd1) begin testsFailed++; $display("[TB] FAIL mid_reach: got (%0d,%0d) expected (700,1)", pixelXD, pixelYD); end
    testsRun++; if (hsyncD !== 1'b0 || videoOnD !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_pre_decode: got hsync=%b video_on=%b expected 0/0", hsyncD, videoOnD); end
    resetD = 1'b1;
    stepClk(1);
    testsRun++; if (pixelXD !== 10'd0 || pixelYD !== 10'd0) begin testsFailed++; $display("[TB] FAIL mid_reset_pos: got (%0d,%0d) expected (0,0)", pixelXD, pixelYD); end
    testsRun++; if (hsyncD !== 1'b1 || vsyncD !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_reset_sync: got hsync=%b vsync=%b expected 1/1", hsyncD, vsyncD); end
    testsRun++; if (videoOnD !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_reset_video: got %b expected 1", videoOnD); end
    testsRun++; if (pTickD !== 1'b0 || lineStartD !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_strobes: got tick=%b line=%b expected 0/0", pTickD, lineStartD); end
    resetD = 1'b0;
    #1;
    stepClk(3);
    testsRun++; if (pTickD !== 1'b1 || pixelXD !== 10'd0) begin testsFailed++; $display("[TB] FAIL mid_first_tick: got tick=%b x=%0d expected 1/0", pTickD, pixelXD); end
    stepClk(1);
    testsRun++; if (pixelXD !== 10'd1 || pixelYD !== 10'd0) begin testsFailed++; $display("[TB] FAIL mid_after_tick: got (%0d,%0d) expected (1,0)", pixelXD, pixelYD); end
  endtask

  // 14x525 raster at CLK_DIV=3: 7350 ticks, 22050 clk per frame, vsync on lines 490..491.
  task automatic test_frame();
    int cyc = 0, fsSeen = 0, fsFirst = -1, fsSecond = -1;
    int lines = 0, vsLow = 0, firstVs = -1, lastVs = -1, vid = 0, ticks = 0;
    resetM = 1'b0;
    #1;
    while (fsSeen < 2 && cyc < 30000) begin
      if (frameStartM === 1'b1) begin
        fsSeen++;
        if (fsSeen == 1) fsFirst = cyc;
        else fsSecond = cyc;
      end
      if (fsSeen == 1) begin
        if (lineStartM === 1'b1) begin
          lines++;
          if (vsyncM === 1'b0) begin
            if (firstVs < 0) firstVs = int'(pixelYM);
            lastVs = int'(pixelYM);
            vsLow++;
          end
        end
        if (pTickM === 1'b1) begin
          ticks++;
          if (videoOnM === 1'b1) vid++;
        end
      end
      if (fsSeen < 2) begin
        stepClk(1);
        cyc++;
      end
    end
    testsRun++; if (fsFirst != 2) begin testsFailed++; $display("[TB] FAIL frame_first_start: got %0d expected 2", fsFirst); end
    testsRun++; if (fsSecond - fsFirst != 22050) begin testsFailed++; $display("[TB] FAIL frame_period_clk: got %0d expected 22050", fsSecond - fsFirst); end
    testsRun++; if (ticks != 7350) begin testsFailed++; $display("[TB] FAIL frame_ticks: got %0d expected 7350", ticks); end
    testsRun++; if (lines != 525) begin testsFailed++; $display("[TB] FAIL frame_line_starts: got %0d expected 525", lines); end
    testsRun++; if (vsLow != 2 || firstVs != 490 || lastVs != 491) begin testsFailed++; $display("[TB] FAIL frame_vsync: got %0d lines %0d..%0d expected 2 lines 490..491", vsLow, firstVs, lastVs); end
    testsRun++; if (vid != 3840) begin testsFailed++; $display("[TB] FAIL frame_video_pixels: got %0d expected 3840", vid); end
  endtask

  // 14x7 raster at CLK_DIV=1: pixel k of the run sits at (k%14, (k/14)%7).
  task automatic test_small();
    int tickErr = 0, posErr = 0, hsErr = 0, vsErr = 0, vidErr = 0, lines = 0;
    int fsFirst = -1, fsSecond = -1;
    int expX, expY;
    resetS = 1'b0;
    #1;
    for (int k = 0; k < 100; k++) begin
      expX = k % 14;
      expY = (k / 14) % 7;
      if (pTickS !== 1'b1) tickErr++;
      if (pixelXS !== 10'(expX) || pixelYS !== 10'(expY)) posErr++;
      if (hsyncS !== ((expX >= 10 && expX <= 11) ? 1'b1 : 1'b0)) hsErr++;
      if (vsyncS !== ((expY == 5) ? 1'b0 : 1'b1)) vsErr++;
      if (videoOnS !== ((expX < 8 && expY < 4) ? 1'b1 : 1'b0)) vidErr++;
      if (lineStartS === 1'b1 && k < 98) lines++;
      if (frameStartS === 1'b1) begin
        if (fsFirst < 0) fsFirst = k;
        else if (fsSecond < 0) fsSecond = k;
      end
      stepClk(1);
    end
    testsRun++; if (tickErr != 0) begin testsFailed++; $display("[TB] FAIL small_tick_const: got %0d low cycles expected 0", tickErr); end
    testsRun++; if (posErr != 0) begin testsFailed++; $display("[TB] FAIL small_position: got %0d bad cycles expected 0", posErr); end
    testsRun++; if (hsErr != 0) begin testsFailed++; $display("[TB] FAIL small_hsync: got %0d bad cycles expected 0", hsErr); end
    testsRun++; if (vsErr != 0) begin testsFailed++; $display("[TB] FAIL small_vsync: got %0d bad cycles expected 0", vsErr); end
    testsRun++; if (vidErr != 0) begin testsFailed++; $display("[TB] FAIL small_video_on: got %0d bad cycles expected 0", vidErr); end
    testsRun++; if (fsFirst != 0 || fsSecond != 98) begin testsFailed++; $display("[TB] FAIL small_frame_period: got %0d,%0d expected 0,98", fsFirst, fsSecond); end
    testsRun++; if (lines != 7) begin testsFailed++; $display("[TB] FAIL small_line_starts: got %0d expected 7", lines); end
  endtask

  // Scenarios run back to back; instances M and S stay in reset until their turn.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetD = 1'b1; enD = 1'b1;
    resetM = 1'b1; enM = 1'b1;
    resetS = 1'b1; enS = 1'b1;
    test_reset();
    test_tick();
    test_line();
    test_en_hold();
    test_reset_mid();
    test_frame();
    test_small();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
